// File: rtl/cpu_pkg.sv
// Shared RV32I encoding definitions: opcodes, request kinds, and a pure
// field-to-word encode function usable by both RTL and bench models.
package cpu_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        KIND_R      = 2'd0,
        KIND_LOAD   = 2'd1,
        KIND_STORE  = 2'd2,
        KIND_BRANCH = 2'd3
    } instr_kind_t;

    // Pure bit selection; the immediate is never sign-extended or range-checked here.
    function automatic logic [31:0] encode(
        input instr_kind_t kind,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  funct3,
        input logic [6:0]  funct7,
        input logic [12:0] imm
    );
        logic [31:0] word;
        case (kind)
            KIND_R:     word = {funct7, rs2, rs1, funct3, rd, OP_R};
            KIND_LOAD:  word = {imm[11:0], rs1, funct3, rd, OP_LOAD};
            KIND_STORE: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
            default:    word = {imm[12], imm[10:5], rs2, rs1, funct3,
                                imm[4:1], imm[11], OP_BRANCH};
        endcase
        return word;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered occupancy; full/empty derive from count_q only,
// so a pop in the same cycle never frees a slot for a push.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointers are AW bits wide, so DEPTH being a power of two gives free wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = empty ? '0 : mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instr_encoder.sv
// Buffered RV32I encoder: packs field requests into R/LOAD/STORE/BRANCH words and
// queues them. Define INSTR_ENC_CHECK_EN to drop illegal immediates and pulse err.
module instr_encoder
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_kind,
    input  logic [4:0]             in_rd,
    input  logic [4:0]             in_rs1,
    input  logic [4:0]             in_rs2,
    input  logic [2:0]             in_funct3,
    input  logic [6:0]             in_funct7,
    input  logic [12:0]            in_imm,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_instr,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err
);

    logic        accept, illegal, push;
    logic        full, empty;
    logic [31:0] word;

    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign accept    = in_valid & in_ready;
    assign word      = encode(instr_kind_t'(in_kind), in_rd, in_rs1, in_rs2,
                              in_funct3, in_funct7, in_imm);

`ifdef INSTR_ENC_CHECK_EN
    logic err_q, err_d;

    // LOAD/STORE immediates must fit 12 signed bits; branch offsets must be even.
    always_comb begin
        illegal = 1'b0;
        case (instr_kind_t'(in_kind))
            KIND_LOAD, KIND_STORE: illegal = (in_imm[12] != in_imm[11]);
            KIND_BRANCH:           illegal = in_imm[0];
            default:               illegal = 1'b0;
        endcase
    end

    always_comb begin
        err_d = accept & illegal;
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err = err_q;
`else
    logic unused_imm0;

    assign unused_imm0 = in_imm[0];
    assign illegal     = 1'b0;
    assign err         = 1'b0;
`endif

    assign push = accept & ~illegal;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (word),
        .pop   (out_ready),
        .rdata (out_instr),
        .count (count),
        .full  (full),
        .empty (empty)
    );

endmodule
